// File: rtl/mul_float_gen.sv
// mul_float_gen: three-stage parametrised floating-point multiplier.
// The format is {sign, P_EXP exponent bits, P_MAN fraction bits}, and subnormal
// inputs are flushed to zero. The rounding mode is selected per request.
// Both sides use a REQ/BUSY handshake and share one global stall.
//
// Ports:
//   iCLOCK, inRESET (async, active-low), iRESET_SYNC (sync, active-high)
//   iDATA_REQ / oDATA_BUSY        : input request / input stall
//   iDATA_A, iDATA_B, iDATA_RM    : operands and rounding mode (0 RNE, 1 RTZ, 2 RUP, 3 RDN)
//   oDATA_VALID / iDATA_BUSY      : result valid / downstream stall
//   oDATA, oFLAG                  : product and {invalid, overflow, underflow, inexact}
module mul_float_gen #(
   parameter int unsigned P_EXP = 8,
   parameter int unsigned P_MAN = 23
) (
   input  logic                   iCLOCK,
   input  logic                   inRESET,
   input  logic                   iRESET_SYNC,
   input  logic                   iDATA_REQ,
   output logic                   oDATA_BUSY,
   input  logic [P_EXP+P_MAN:0]   iDATA_A,
   input  logic [P_EXP+P_MAN:0]   iDATA_B,
   input  logic [1:0]             iDATA_RM,
   output logic                   oDATA_VALID,
   input  logic                   iDATA_BUSY,
   output logic [P_EXP+P_MAN:0]   oDATA,
   output logic [3:0]             oFLAG
);

   localparam int unsigned W       = 1 + P_EXP + P_MAN;
   localparam int unsigned EW      = P_EXP + 2;          // signed internal exponent width
   localparam int unsigned MW      = P_MAN + 1;          // mantissa incl. hidden bit
   localparam int unsigned PW      = 2 * MW;             // full mantissa product width
   localparam int unsigned BIAS    = (1 << (P_EXP - 1)) - 1;
   localparam int unsigned EXP_MAX = (1 << P_EXP) - 1;

   localparam logic [1:0] RM_RNE = 2'd0;
   localparam logic [1:0] RM_RTZ = 2'd1;
   localparam logic [1:0] RM_RUP = 2'd2;

   // Result class decided in S1 and carried down the pipe.
   localparam logic [1:0] CLS_NUM  = 2'd0;
   localparam logic [1:0] CLS_ZERO = 2'd1;
   localparam logic [1:0] CLS_INF  = 2'd2;
   localparam logic [1:0] CLS_NAN  = 2'd3;

   localparam logic [P_EXP-1:0] EXP_ONES = '1;

   // ---------------------------------------------------------------
   // Handshake: one stall freezes all three stages.
   // ---------------------------------------------------------------
   logic stall_c;
   logic accept_c;
   logic adv_c;

   logic s1_valid_q, s2_valid_q, out_valid_q;

   assign stall_c    = out_valid_q && iDATA_BUSY;
   assign adv_c      = !stall_c;
   assign accept_c   = iDATA_REQ && !stall_c;
   assign oDATA_BUSY = stall_c;

   // ---------------------------------------------------------------
   // S1: unpack, classify, exponent sum, mantissa product
   // ---------------------------------------------------------------
   logic             sign_a, sign_b;
   logic [P_EXP-1:0] exp_a, exp_b;
   logic [P_MAN-1:0] frac_a, frac_b;
   logic             a_zero, a_inf, a_nan, a_snan;
   logic             b_zero, b_inf, b_nan, b_snan;

   assign sign_a = iDATA_A[W-1];
   assign sign_b = iDATA_B[W-1];
   assign exp_a  = iDATA_A[W-2 -: P_EXP];
   assign exp_b  = iDATA_B[W-2 -: P_EXP];
   assign frac_a = iDATA_A[P_MAN-1:0];
   assign frac_b = iDATA_B[P_MAN-1:0];

   // A zero exponent field is treated as zero whatever the fraction holds.
   assign a_zero = (exp_a == '0);
   assign a_inf  = (exp_a == EXP_ONES) && (frac_a == '0);
   assign a_nan  = (exp_a == EXP_ONES) && (frac_a != '0);
   assign a_snan = a_nan && !frac_a[P_MAN-1];
   assign b_zero = (exp_b == '0);
   assign b_inf  = (exp_b == EXP_ONES) && (frac_b == '0);
   assign b_nan  = (exp_b == EXP_ONES) && (frac_b != '0);
   assign b_snan = b_nan && !frac_b[P_MAN-1];

   logic          s1_sign_d, s1_sign_q;
   logic [1:0]    s1_cls_d,  s1_cls_q;
   logic          s1_inv_d,  s1_inv_q;
   logic [EW-1:0] s1_exp_d,  s1_exp_q;
   logic [PW-1:0] s1_prod_d, s1_prod_q;
   logic [1:0]    s1_rm_q;

   // Special-case priority: NaN / 0*inf, then inf, then zero.
   always_comb begin
      s1_cls_d  = CLS_NUM;
      s1_inv_d  = 1'b0;
      s1_sign_d = sign_a ^ sign_b;
      s1_exp_d  = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);
      s1_prod_d = PW'({1'b1, frac_a}) * PW'({1'b1, frac_b});
      if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
         s1_cls_d = CLS_NAN;
         s1_inv_d = a_snan || b_snan || (a_zero && b_inf) || (a_inf && b_zero);
      end else if (a_inf || b_inf) begin
         s1_cls_d = CLS_INF;
      end else if (a_zero || b_zero) begin
         s1_cls_d = CLS_ZERO;
      end
   end

   // ---------------------------------------------------------------
   // S2: normalise to 1.x, derive guard and sticky
   // ---------------------------------------------------------------
   logic          s2_sign_q;
   logic [1:0]    s2_cls_q;
   logic          s2_inv_q;
   logic [1:0]    s2_rm_q;
   logic [EW-1:0] s2_exp_d, s2_exp_q;
   logic [MW-1:0] s2_man_d, s2_man_q;
   logic          s2_g_d,   s2_g_q;
   logic          s2_s_d,   s2_s_q;

   // Product of two 1.x values lies in [1,4); a set MSB means shift right by one.
   always_comb begin
      s2_exp_d = s1_exp_q;
      s2_man_d = s1_prod_q[PW-2 -: MW];
      s2_g_d   = s1_prod_q[P_MAN-1];
      s2_s_d   = |s1_prod_q[P_MAN-2:0];
      if (s1_prod_q[PW-1]) begin
         s2_exp_d = s1_exp_q + EW'(1);
         s2_man_d = s1_prod_q[PW-1 -: MW];
         s2_g_d   = s1_prod_q[P_MAN];
         s2_s_d   = |s1_prod_q[P_MAN-1:0];
      end
   end

   // ---------------------------------------------------------------
   // S3: round, range check, pack
   // ---------------------------------------------------------------
   logic          inexact_c;
   logic          round_up_c;
   logic [MW:0]   man_r_c;
   logic          carry_c;
   logic [P_MAN-1:0] frac_r_c;
   logic [EW-1:0] exp_r_c;
   logic          underflow_c;
   logic          overflow_c;
   logic          to_inf_c;
   logic [W-1:0]  s3_data_d;
   logic [3:0]    s3_flag_d;
   logic [W-1:0]  out_data_q;
   logic [3:0]    out_flag_q;

   always_comb begin
      inexact_c = s2_g_q | s2_s_q;
      case (s2_rm_q)
         RM_RNE:  round_up_c = s2_g_q && (s2_s_q || s2_man_q[0]);
         RM_RTZ:  round_up_c = 1'b0;
         RM_RUP:  round_up_c = inexact_c && !s2_sign_q;
         default: round_up_c = inexact_c && s2_sign_q;
      endcase
      man_r_c = {1'b0, s2_man_q} + (MW+1)'(round_up_c);
      // A carry out means the mantissa became exactly 10.0...0.
      carry_c  = man_r_c[MW];
      frac_r_c = carry_c ? man_r_c[P_MAN:1] : man_r_c[P_MAN-1:0];
      exp_r_c  = s2_exp_q + EW'(carry_c);
      // Underflow is judged before rounding, overflow after.
      underflow_c = $signed(s2_exp_q) < $signed(EW'(1));
      overflow_c  = $signed(exp_r_c) >= $signed(EW'(EXP_MAX));
      to_inf_c    = (s2_rm_q == RM_RNE) ||
                    ((s2_rm_q == RM_RUP) && !s2_sign_q) ||
                    ((s2_rm_q == 2'd3) && s2_sign_q);
   end

   always_comb begin
      s3_data_d = {s2_sign_q, exp_r_c[P_EXP-1:0], frac_r_c};
      s3_flag_d = {3'b000, inexact_c};
      case (s2_cls_q)
         CLS_NAN: begin
            s3_data_d = {1'b0, EXP_ONES, 1'b1, (P_MAN-1)'(0)};
            s3_flag_d = {s2_inv_q, 3'b000};
         end
         CLS_INF: begin
            s3_data_d = {s2_sign_q, EXP_ONES, P_MAN'(0)};
            s3_flag_d = 4'b0000;
         end
         CLS_ZERO: begin
            s3_data_d = {s2_sign_q, P_EXP'(0), P_MAN'(0)};
            s3_flag_d = 4'b0000;
         end
         default: begin
            if (underflow_c) begin
               s3_data_d = {s2_sign_q, P_EXP'(0), P_MAN'(0)};
               s3_flag_d = 4'b0011;
            end else if (overflow_c) begin
               s3_flag_d = 4'b0101;
               if (to_inf_c) begin
                  s3_data_d = {s2_sign_q, EXP_ONES, P_MAN'(0)};
               end else begin
                  s3_data_d = {s2_sign_q, EXP_ONES - P_EXP'(1), {P_MAN{1'b1}}};
               end
            end
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Stage valids and output registers: both resets clear them.
   // ---------------------------------------------------------------
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flag_q  <= '0;
      end else if (iRESET_SYNC) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flag_q  <= '0;
      end else if (adv_c) begin
         s1_valid_q  <= accept_c;
         s2_valid_q  <= s1_valid_q;
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_data_q <= s3_data_d;
            out_flag_q <= s3_flag_d;
         end
      end
   end

   // Datapath payload registers, qualified by the stage valids above.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         s1_sign_q <= 1'b0;
         s1_cls_q  <= CLS_ZERO;
         s1_inv_q  <= 1'b0;
         s1_exp_q  <= '0;
         s1_prod_q <= '0;
         s1_rm_q   <= RM_RNE;
         s2_sign_q <= 1'b0;
         s2_cls_q  <= CLS_ZERO;
         s2_inv_q  <= 1'b0;
         s2_rm_q   <= RM_RNE;
         s2_exp_q  <= '0;
         s2_man_q  <= '0;
         s2_g_q    <= 1'b0;
         s2_s_q    <= 1'b0;
      end else if (adv_c) begin
         s1_sign_q <= s1_sign_d;
         s1_cls_q  <= s1_cls_d;
         s1_inv_q  <= s1_inv_d;
         s1_exp_q  <= s1_exp_d;
         s1_prod_q <= s1_prod_d;
         s1_rm_q   <= iDATA_RM;
         s2_sign_q <= s1_sign_q;
         s2_cls_q  <= s1_cls_q;
         s2_inv_q  <= s1_inv_q;
         s2_rm_q   <= s1_rm_q;
         s2_exp_q  <= s2_exp_d;
         s2_man_q  <= s2_man_d;
         s2_g_q    <= s2_g_d;
         s2_s_q    <= s2_s_d;
      end
   end

   assign oDATA_VALID = out_valid_q;
   assign oDATA       = out_data_q;
   assign oFLAG       = out_flag_q;

endmodule
